// File: rtl/idct_pkg.sv
// idct_pkg: shared FSM state type, block constants and Q1.14 cosine table for the 8-point IDCT
package idct_pkg;
    typedef enum logic [1:0] {LOAD, MAC, OUT} state_t;
    localparam int BLOCK_N = 8;
    localparam int COS_FRAC = 14;
    localparam int ROUND_CONST = 8192;
    localparam logic signed [15:0] COS_LUT [64] = '{
        16'sd5793,  16'sd8035,  16'sd7568,  16'sd6811,  16'sd5793,  16'sd4551,  16'sd3135,  16'sd1598,
        16'sd5793,  16'sd6811,  16'sd3135, -16'sd1598, -16'sd5793, -16'sd8035, -16'sd7568, -16'sd4551,
        16'sd5793,  16'sd4551, -16'sd3135, -16'sd8035, -16'sd5793,  16'sd1598,  16'sd7568,  16'sd6811,
        16'sd5793,  16'sd1598, -16'sd7568, -16'sd4551,  16'sd5793,  16'sd6811, -16'sd3135, -16'sd8035,
        16'sd5793, -16'sd1598, -16'sd7568,  16'sd4551,  16'sd5793, -16'sd6811, -16'sd3135,  16'sd8035,
        16'sd5793, -16'sd4551, -16'sd3135,  16'sd8035, -16'sd5793, -16'sd1598,  16'sd7568, -16'sd6811,
        16'sd5793, -16'sd6811,  16'sd3135,  16'sd1598, -16'sd5793,  16'sd8035, -16'sd7568,  16'sd4551,
        16'sd5793, -16'sd8035,  16'sd7568, -16'sd6811,  16'sd5793, -16'sd4551,  16'sd3135, -16'sd1598
    };
endpackage

// File: rtl/idct_cos_lut.sv
// idct_cos_lut: combinational cosine table addressed by {n, k}
module idct_cos_lut
    import idct_pkg::*;
(
    input  logic [5:0]         addr_i,
    output logic signed [15:0] cos_o
);
    assign cos_o = COS_LUT[addr_i];
endmodule

// File: rtl/idct_8pt_seq.sv
// idct_8pt_seq: sequential 8-point IDCT, load 8 coefficients, 64 MAC cycles, stream 8 samples
module idct_8pt_seq
    import idct_pkg::*;
#(
    parameter int bit_width = 16
) (
    input  logic                 gated_clk,
    input  logic                 rst,
    input  logic [bit_width-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [bit_width-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 out_sat,
    output logic                 busy
);
    localparam int ACC_W = bit_width + 19;
    localparam int PROD_W = bit_width + 16;
    localparam int CNT_W = $clog2(BLOCK_N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_N - 1);
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-bit_width+1){1'b0}}, {(bit_width-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    state_t state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d, n_q, n_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, sum, rnd;
    logic signed [PROD_W-1:0] prod;
    logic signed [15:0] cos_w;
    logic [bit_width-1:0] coef_q [BLOCK_N];
    logic [bit_width-1:0] res_q [BLOCK_N];
    logic [BLOCK_N-1:0] sat_q;
    logic in_fire, out_fire, row_end, mac_last, res_hi, res_lo;

    idct_cos_lut u_lut (.addr_i({n_q, k_q}), .cos_o(cos_w));

    assign in_fire = state_q == LOAD && in_valid;
    assign out_fire = state_q == OUT && out_ready;
    assign row_end = state_q == MAC && k_q == LAST;
    assign mac_last = row_end && n_q == LAST;
    assign prod = $signed(coef_q[k_q]) * cos_w;
    assign sum = acc_q + ACC_W'(prod);
    assign rnd = (sum + ACC_W'(ROUND_CONST)) >>> COS_FRAC;
    assign res_hi = rnd > MAX_V;
    assign res_lo = rnd < MIN_V;

    // State register
    always_ff @(posedge gated_clk) begin
        if (rst) state_q <= LOAD;
        else state_q <= state_d;
    end

    // Next state: last coefficient starts MAC, last product starts OUT, last handshake reloads
    always_comb begin
        state_d = (in_fire && k_q == LAST) ? MAC :
                  mac_last ? OUT :
                  (out_fire && n_q == LAST) ? LOAD : state_q;
    end

    // Outputs decoded from state; slot n_q is presented while in OUT
    always_comb begin
        in_ready = state_q == LOAD;
        out_valid = state_q == OUT;
        busy = state_q != LOAD;
        out_data = state_q == OUT ? res_q[n_q] : '0;
        out_last = state_q == OUT && n_q == LAST;
        out_sat = state_q == OUT && sat_q[n_q];
    end

    // Counter and accumulator next values; 3-bit counters wrap back to 0 after slot 7
    always_comb begin
        k_d = (in_fire || state_q == MAC) ? k_q + 1'b1 : k_q;
        n_d = (row_end || out_fire) ? n_q + 1'b1 : n_q;
        acc_d = (state_q == MAC && !row_end) ? sum : '0;
    end

    // Counter and accumulator registers
    always_ff @(posedge gated_clk) begin
        if (rst) begin
            k_q <= '0;
            n_q <= '0;
            acc_q <= '0;
        end else begin
            k_q <= k_d;
            n_q <= n_d;
            acc_q <= acc_d;
        end
    end

    // Coefficient and result buffers keep their contents across reset
    always_ff @(posedge gated_clk) begin
        if (in_fire) coef_q[k_q] <= in_data;
        if (row_end) begin
            res_q[n_q] <= res_hi ? MAX_V[bit_width-1:0] : res_lo ? MIN_V[bit_width-1:0] : rnd[bit_width-1:0];
            sat_q[n_q] <= res_hi || res_lo;
        end
    end
endmodule

// File: doc/idct_8pt_seq.md
IDCT_8PT_SEQ -- requirements
Module: idct_8pt_seq

Interface
REQ-001 The block SHALL have parameter bit_width, default 16, setting the width of coefficient input and sample output.
REQ-002 gated_clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_data  input  bit_width  signed DCT coefficient X(k), two's complement.
REQ-005 in_valid  input  1  in_data holds a valid coefficient.
REQ-006 in_ready  output  1  block accepts a coefficient this cycle.
REQ-007 out_data  output  bit_width  signed reconstructed sample x(n).
REQ-008 out_valid  output  1  out_data holds a valid sample.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_last  output  1  high with out_valid on sample n=7.
REQ-011 out_sat  output  1  high with out_valid when the presented sample was saturated.
REQ-012 busy  output  1  high in any state other than LOAD.

Function
REQ-013 The FSM SHALL have exactly three states: LOAD, MAC, OUT.
REQ-014 LOAD: in_ready=1; each cycle with in_valid=1 stores in_data into coefficient buffer slot k, then k increments from 0 to 7.
REQ-015 When slot 7 is written at cycle T, the FSM SHALL enter MAC at T+1 and clear k.
REQ-016 in_valid outside LOAD SHALL be ignored; in_ready=0 in MAC and OUT.
REQ-017 MAC SHALL take exactly 64 cycles (T+1..T+64), one multiply-accumulate per cycle, with n outer 0..7 and k inner 0..7.
REQ-018 Each product SHALL be X(k) times LUT(n,k), where LUT(n,k)=round(16384*0.5*c(k)*cos((2n+1)k*pi/16)), c(0)=1/sqrt2, c(k>0)=1, signed 16-bit Q1.14.
REQ-019 The accumulator SHALL be at least bit_width+19 bits wide, so no intermediate overflow occurs.
REQ-020 On k=7 for each n, result=(acc+product+8192)>>>14 (arithmetic), saturated to [-2^(bit_width-1), 2^(bit_width-1)-1]; result and its saturation bit are written to output buffer slot n, and the accumulator clears for the next n.
REQ-021 The FSM SHALL enter OUT at T+65 with out_valid=1 presenting slot 0.
REQ-022 OUT: out_data, out_valid, out_last and out_sat SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 OUT: each cycle with out_valid=1 and out_ready=1 advances to the next slot; no bubble is inserted between samples.
REQ-024 The handshake on slot 7 SHALL return the FSM to LOAD, with in_ready=1 in the next cycle.
REQ-025 out_valid SHALL be 0 in LOAD and MAC.
REQ-026 Coefficient buffer contents SHALL be retained until overwritten by the next block.

Reset
REQ-027 With rst high at a clock edge, the next state SHALL be LOAD, with k=0, n=0, accumulator=0, in_ready=1, out_valid=0, out_last=0, out_sat=0, out_data=0 and busy=0.
REQ-028 Reset during MAC or OUT SHALL discard the block in progress; no further samples of that block appear.
REQ-029 Coefficient and output buffer contents need not be cleared by reset.

Structure
REQ-030 Shared package idct_pkg SHALL hold:
- the state typedef (LOAD, MAC, OUT);
- BLOCK_N=8, COS_FRAC=14, ROUND_CONST=8192;
- the 64 LUT constants.
REQ-031 The LUT SHALL be a combinational sub-module idct_cos_lut, addressed by {n[2:0],k[2:0]} and returning a signed 16-bit value.
REQ-032 No multiplier other than the single MAC multiplier SHALL be instantiated.

Verification
REQ-033 DC block: X0=8192, X1..X7=0 -> eight samples all 2897, out_sat=0, out_last only on the 8th sample, first out_valid exactly 65 cycles after the 8th accept.
REQ-034 All-zero block -> eight samples of 0; in_ready returns to 1 the cycle after the 8th output handshake.
REQ-035 Saturation: X0..X7 all 32767 -> sample n=0 equals 32767 with out_sat=1.
REQ-036 Backpressure: out_ready low for 5 cycles after out_valid rises, in_valid held high throughout -> out_data and out_valid stable, in_ready=0, no coefficient consumed.
REQ-037 Reset asserted on the 30th MAC cycle -> next cycle in_ready=1 and out_valid=0; a following DC block (X0=8192) yields all samples 2897.
REQ-038 Two back-to-back blocks with out_ready tied high -> 16 correct samples, with exactly two out_last pulses.
